// File: rtl/etc_lane_scheduler_pkg.sv
// Shared types and default widths for the non-stop ETC lane core and its billing scheduler.
package etc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_GRANT    = 2'd3
    } etc_state_e;

    localparam int ETC_TIK_PER_MS  = 50000;
    localparam int ETC_WIDTH_SPEED = 14;
    localparam int ETC_WIDTH_MS    = 9;
    localparam int ETC_WIDTH_TIK   = 16;

endpackage

// File: rtl/etc_lane_scheduler_if.sv
// Request/verdict port between the lane scheduler (master) and the billing engine (slave).
interface etc_lane_scheduler_if
    import etc_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int WIDTH_SPEED = ETC_WIDTH_SPEED
);

    logic                         bill_req_valid;
    logic                         bill_req_ready;
    logic [$clog2(NUM_LANES)-1:0] bill_req_lane;
    logic [WIDTH_SPEED-1:0]       bill_req_speed;
    logic                         bill_rsp_valid;
    logic                         bill_rsp_ok;

    modport master (
        output bill_req_valid,
        output bill_req_lane,
        output bill_req_speed,
        input  bill_req_ready,
        input  bill_rsp_valid,
        input  bill_rsp_ok
    );

    modport slave (
        input  bill_req_valid,
        input  bill_req_lane,
        input  bill_req_speed,
        output bill_req_ready,
        output bill_rsp_valid,
        output bill_rsp_ok
    );

endinterface

// File: rtl/etc_lane_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first pending lane at or after ptr, wrapping.
module etc_rr_arbiter #(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES-1:0]         pending,
    input  logic [$clog2(NUM_LANES)-1:0] ptr,
    output logic [$clog2(NUM_LANES)-1:0] idx,
    output logic                         any
);

    localparam int IDX_W = $clog2(NUM_LANES);

    // One spare bit so ptr + offset never overflows before the wrap.
    logic [IDX_W:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 0; off < NUM_LANES; off++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (cand >= (IDX_W + 1)'(NUM_LANES)) begin
                cand = cand - (IDX_W + 1)'(NUM_LANES);
            end
            if (!any && pending[cand[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/etc_lane_scheduler.sv
// Shares one billing engine among NUM_LANES lane cores: captures done+speed, serves lanes
// round-robin, waits for the verdict with a ms timeout and drives barrier-open permission.
module etc_lane_scheduler
    import etc_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int WIDTH_SPEED = ETC_WIDTH_SPEED,
    parameter int WIDTH_TIK   = ETC_WIDTH_TIK,
    parameter int TIK_PER_MS  = ETC_TIK_PER_MS,
    parameter int WIDTH_MS    = ETC_WIDTH_MS,
    parameter int TIMEOUT_MS  = 200,
    parameter int SPEED_LIMIT = 60
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_LANES-1:0]             lane_done,
    input  logic [NUM_LANES*WIDTH_SPEED-1:0] lane_speed,
    input  logic [NUM_LANES-1:0]             lane_clear,
    etc_lane_scheduler_if.master             bill,
    output logic [NUM_LANES-1:0]             lane_open,
    output logic [NUM_LANES-1:0]             lane_ack,
    output logic                             timeout_err,
    output logic [NUM_LANES-1:0]             overrun
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam logic [WIDTH_TIK-1:0]   TIK_LAST  = WIDTH_TIK'(TIK_PER_MS - 1);
    localparam logic [WIDTH_MS-1:0]    MS_LIMIT  = WIDTH_MS'(TIMEOUT_MS);
    localparam logic [WIDTH_SPEED-1:0] SPD_LIMIT = WIDTH_SPEED'(SPEED_LIMIT);

    logic [NUM_LANES-1:0]   done_prev_q;
    logic [NUM_LANES-1:0]   pending_q, pending_d;
    logic [NUM_LANES-1:0]   overrun_q, overrun_d;
    logic [NUM_LANES-1:0]   open_q, open_d;
    logic [WIDTH_SPEED-1:0] speed_q [NUM_LANES];

    logic [NUM_LANES-1:0]   done_rise;
    logic [NUM_LANES-1:0]   grant_clr;
    logic [NUM_LANES-1:0]   open_set;
    logic                   speed_ok;

    etc_state_e             state_q;
    logic [IDX_W-1:0]       lane_q;
    logic [IDX_W-1:0]       ptr_q;
    logic                   req_valid_q;
    logic [WIDTH_SPEED-1:0] req_speed_q;
    logic [WIDTH_TIK-1:0]   tik_q;
    logic [WIDTH_MS-1:0]    ms_q;
    logic                   ok_q;
    logic [NUM_LANES-1:0]   ack_q;
    logic                   timeout_q;

    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    etc_rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_arb (
        .pending (pending_q),
        .ptr     (ptr_q),
        .idx     (arb_idx),
        .any     (arb_any)
    );

    // Verdict applies to the speed actually sent to billing, not a later overwrite.
    assign speed_ok = (req_speed_q <= SPD_LIMIT);

    always_comb begin
        done_rise = lane_done & ~done_prev_q;
        grant_clr = '0;
        open_set  = '0;
        if (state_q == ST_GRANT) begin
            grant_clr[lane_q] = 1'b1;
            if (ok_q && speed_ok) begin
                open_set[lane_q] = 1'b1;
            end
        end
        // A fresh done edge beats the grant clear; it is a new vehicle, not an overrun.
        pending_d = (pending_q & ~grant_clr) | done_rise;
        overrun_d = overrun_q | (done_rise & pending_q & ~grant_clr);
        open_d    = (open_q & ~lane_clear) | open_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_prev_q <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
            open_q      <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                speed_q[i] <= '0;
            end
        end else begin
            done_prev_q <= lane_done;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            open_q      <= open_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (done_rise[i]) begin
                    speed_q[i] <= lane_speed[i*WIDTH_SPEED +: WIDTH_SPEED];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            ptr_q       <= '0;
            req_valid_q <= 1'b0;
            req_speed_q <= '0;
            tik_q       <= '0;
            ms_q        <= '0;
            ok_q        <= 1'b0;
            ack_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            ack_q     <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        lane_q      <= arb_idx;
                        req_speed_q <= speed_q[arb_idx];
                        req_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bill.bill_req_ready) begin
                        req_valid_q <= 1'b0;
                        tik_q       <= '0;
                        ms_q        <= '0;
                        state_q     <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (tik_q == TIK_LAST) begin
                        tik_q <= '0;
                        ms_q  <= ms_q + 1'b1;
                    end else begin
                        tik_q <= tik_q + 1'b1;
                    end
                    // A verdict arriving on the timeout cycle still counts.
                    if (bill.bill_rsp_valid) begin
                        ok_q          <= bill.bill_rsp_ok;
                        ack_q[lane_q] <= 1'b1;
                        state_q       <= ST_GRANT;
                    end else if (ms_q == MS_LIMIT) begin
                        ok_q          <= 1'b0;
                        ack_q[lane_q] <= 1'b1;
                        timeout_q     <= 1'b1;
                        state_q       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    ptr_q   <= (lane_q == IDX_W'(NUM_LANES - 1)) ? '0 : lane_q + 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bill.bill_req_valid = req_valid_q;
    assign bill.bill_req_lane  = lane_q;
    assign bill.bill_req_speed = req_speed_q;
    assign lane_open           = open_q;
    assign lane_ack            = ack_q;
    assign timeout_err         = timeout_q;
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_etc_lane_scheduler.sv
// Bench for etc_lane_scheduler: vector table, hand-written corner sequences and randomized batches.
module tb_etc_lane_scheduler;

    localparam int NL = 4;
    localparam int WS = 14;

    logic          clk;
    logic          reset_n;
    logic [NL-1:0] lane_done;
    logic [NL*WS-1:0] lane_speed;
    logic [NL-1:0] lane_clear;
    logic [NL-1:0] lane_open;
    logic [NL-1:0] lane_ack;
    logic          timeout_err;
    logic [NL-1:0] overrun;

    etc_lane_scheduler_if #(.NUM_LANES(NL), .WIDTH_SPEED(WS)) bif ();

    etc_lane_scheduler #(
        .NUM_LANES   (NL),
        .WIDTH_SPEED (WS),
        .WIDTH_TIK   (16),
        .TIK_PER_MS  (50),
        .WIDTH_MS    (9),
        .TIMEOUT_MS  (200),
        .SPEED_LIMIT (60)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lane_done   (lane_done),
        .lane_speed  (lane_speed),
        .lane_clear  (lane_clear),
        .bill        (bif),
        .lane_open   (lane_open),
        .lane_ack    (lane_ack),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    int ptr_m   = 0;
    int ack_cnt [NL];

    initial begin
        for (int i = 0; i < NL; i++) ack_cnt[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (lane_ack[i]) ack_cnt[i] = ack_cnt[i] + 1;
        end
    end

    typedef struct {
        int lane;
        int speed;
        bit ok;
        int rsp_dly;
        bit exp_open;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_done(input int ln, input int spd);
        lane_done[ln] = 1'b1;
        lane_speed[ln*WS +: WS] = WS'(spd);
        step();
        lane_done[ln] = 1'b0;
        step();
    endtask

    task automatic wait_valid(output bit seen);
        int n;
        n = 0;
        while (!bif.bill_req_valid && n < 50) begin
            step();
            n++;
        end
        seen = bif.bill_req_valid;
    endtask

    task automatic serve_one(input int ln, input int spd, input bit ok, input int rsp_dly,
                             input int rdy_dly, input bit exp_open, input bit do_clear);
        bit seen;
        bit stable;
        wait_valid(seen);
        check("req_valid", int'(seen), 1);
        check("req_lane", int'(bif.bill_req_lane), ln);
        check("req_speed", int'(bif.bill_req_speed), spd);
        stable = 1'b1;
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            if (!bif.bill_req_valid || int'(bif.bill_req_lane) != ln ||
                int'(bif.bill_req_speed) != spd) stable = 1'b0;
        end
        if (rdy_dly > 0) check("backpressure_hold", int'(stable), 1);
        bif.bill_req_ready = 1'b1;
        step();
        bif.bill_req_ready = 1'b0;
        check("valid_after_xfer", int'(bif.bill_req_valid), 0);
        repeat (rsp_dly) step();
        bif.bill_rsp_valid = 1'b1;
        bif.bill_rsp_ok    = ok;
        step();
        bif.bill_rsp_valid = 1'b0;
        bif.bill_rsp_ok    = 1'b0;
        check("lane_ack", int'(lane_ack), 1 << ln);
        check("timeout_quiet", int'(timeout_err), 0);
        step();
        check("lane_open", int'(lane_open[ln]), int'(exp_open));
        ptr_m = (ln + 1) % NL;
        if (exp_open) begin
            repeat (2) step();
            check("lane_open_held", int'(lane_open[ln]), 1);
        end
        if (do_clear) begin
            lane_clear[ln] = 1'b1;
            step();
            lane_clear[ln] = 1'b0;
            check("lane_open_cleared", int'(lane_open[ln]), 0);
        end
    endtask

    initial begin
        int snap [NL];
        int n;
        bit seen;
        bit quiet;

        tbl[0] = '{2, 40,    1'b1, 3, 1'b1};
        tbl[1] = '{1, 60,    1'b1, 0, 1'b1};
        tbl[2] = '{0, 61,    1'b1, 1, 1'b0};
        tbl[3] = '{3, 40,    1'b0, 2, 1'b0};
        tbl[4] = '{2, 0,     1'b1, 5, 1'b1};
        tbl[5] = '{1, 16383, 1'b1, 1, 1'b0};

        reset_n = 1'b0;
        lane_done = '0;
        lane_speed = '0;
        lane_clear = '0;
        bif.bill_req_ready = 1'b0;
        bif.bill_rsp_valid = 1'b0;
        bif.bill_rsp_ok    = 1'b0;
        repeat (3) step();
        check("rst_req_valid", int'(bif.bill_req_valid), 0);
        check("rst_lane_open", int'(lane_open), 0);
        check("rst_lane_ack", int'(lane_ack), 0);
        check("rst_timeout", int'(timeout_err), 0);
        check("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        step();
        ptr_m = 0;

        // Fairness: lanes 0,1,3 together from ptr 0, then 0 and 3 again.
        for (int i = 0; i < NL; i++) snap[i] = ack_cnt[i];
        lane_done = 4'b1011;
        lane_speed[0*WS +: WS] = 14'd10;
        lane_speed[1*WS +: WS] = 14'd20;
        lane_speed[3*WS +: WS] = 14'd30;
        step();
        lane_done = '0;
        serve_one(0, 10, 1'b1, 1, 0, 1'b1, 1'b1);
        serve_one(1, 20, 1'b1, 0, 0, 1'b1, 1'b1);
        serve_one(3, 30, 1'b1, 2, 0, 1'b1, 1'b1);
        lane_done = 4'b1001;
        lane_speed[0*WS +: WS] = 14'd45;
        lane_speed[3*WS +: WS] = 14'd55;
        step();
        lane_done = '0;
        serve_one(0, 45, 1'b1, 0, 0, 1'b1, 1'b1);
        serve_one(3, 55, 1'b0, 1, 0, 1'b0, 1'b0);
        repeat (3) step();
        check("fair_acks_l0", ack_cnt[0] - snap[0], 2);
        check("fair_acks_l1", ack_cnt[1] - snap[1], 1);
        check("fair_acks_l2", ack_cnt[2] - snap[2], 0);
        check("fair_acks_l3", ack_cnt[3] - snap[3], 2);

        for (int t = 0; t < 6; t++) begin
            raise_done(tbl[t].lane, tbl[t].speed);
            serve_one(tbl[t].lane, tbl[t].speed, tbl[t].ok, tbl[t].rsp_dly, 0,
                      tbl[t].exp_open, 1'b1);
        end

        // Backpressure: ready withheld for 10 cycles.
        raise_done(2, 33);
        serve_one(2, 33, 1'b1, 0, 10, 1'b1, 1'b1);

        // Overrun: lane 0 done twice while lane 3 is being served.
        raise_done(3, 20);
        wait_valid(seen);
        raise_done(0, 50);
        raise_done(0, 61);
        check("overrun_set", int'(overrun), 1);
        serve_one(3, 20, 1'b1, 2, 0, 1'b1, 1'b1);
        serve_one(0, 61, 1'b1, 1, 0, 1'b0, 1'b1);
        check("overrun_sticky", int'(overrun), 1);

        // Randomized batches against a round-robin reference order.
        for (int b = 0; b < 20; b++) begin
            int set;
            int spd [NL];
            int order [$];
            bit okr;
            set = int'($urandom_range(1, 15));
            for (int i = 0; i < NL; i++) begin
                spd[i] = int'($urandom_range(0, 120));
                if (set[i]) begin
                    lane_done[i] = 1'b1;
                    lane_speed[i*WS +: WS] = WS'(spd[i]);
                end
            end
            step();
            lane_done = '0;
            order = {};
            for (int k = 0; k < NL; k++) begin
                if (set[(ptr_m + k) % NL]) order.push_back((ptr_m + k) % NL);
            end
            foreach (order[q]) begin
                okr = 1'($urandom_range(0, 1));
                serve_one(order[q], spd[order[q]], okr, int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 3)), okr && (spd[order[q]] <= 60), 1'b1);
            end
        end

        // Timeout: no verdict, pulse expected about 200 ms after transfer.
        raise_done(1, 10);
        wait_valid(seen);
        check("to_req_lane", int'(bif.bill_req_lane), 1);
        bif.bill_req_ready = 1'b1;
        step();
        bif.bill_req_ready = 1'b0;
        n = 0;
        while (!timeout_err && n < 10100) begin
            step();
            n++;
        end
        check("timeout_seen", int'(timeout_err), 1);
        check("timeout_window", int'(n >= 10000 && n <= 10001), 1);
        check("timeout_ack", int'(lane_ack), 2);
        step();
        check("timeout_no_open", int'(lane_open[1]), 0);
        check("timeout_one_cycle", int'(timeout_err), 0);
        bif.bill_rsp_valid = 1'b1;
        bif.bill_rsp_ok    = 1'b1;
        step();
        bif.bill_rsp_valid = 1'b0;
        bif.bill_rsp_ok    = 1'b0;
        step();
        check("late_rsp_no_ack", int'(lane_ack), 0);
        check("late_rsp_no_open", int'(lane_open[1]), 0);
        ptr_m = 2;

        // Verdict on the timeout cycle: the verdict wins.
        raise_done(1, 10);
        wait_valid(seen);
        bif.bill_req_ready = 1'b1;
        step();
        bif.bill_req_ready = 1'b0;
        repeat (10000) step();
        bif.bill_rsp_valid = 1'b1;
        bif.bill_rsp_ok    = 1'b1;
        step();
        bif.bill_rsp_valid = 1'b0;
        bif.bill_rsp_ok    = 1'b0;
        check("tie_ack", int'(lane_ack), 2);
        check("tie_no_timeout", int'(timeout_err), 0);
        step();
        check("tie_open", int'(lane_open[1]), 1);

        // Reset in WAIT_RSP with an open barrier and another lane queued.
        lane_done = 4'b1100;
        lane_speed[2*WS +: WS] = 14'd5;
        lane_speed[3*WS +: WS] = 14'd7;
        step();
        lane_done = '0;
        wait_valid(seen);
        check("rst_test_lane", int'(bif.bill_req_lane), 2);
        bif.bill_req_ready = 1'b1;
        step();
        bif.bill_req_ready = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_open", int'(lane_open), 0);
        check("async_rst_overrun", int'(overrun), 0);
        check("async_rst_valid", int'(bif.bill_req_valid), 0);
        step();
        reset_n = 1'b1;
        bif.bill_rsp_valid = 1'b1;
        bif.bill_rsp_ok    = 1'b1;
        step();
        bif.bill_rsp_valid = 1'b0;
        bif.bill_rsp_ok    = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bif.bill_req_valid || lane_ack != '0 || lane_open != '0) quiet = 1'b0;
            step();
        end
        check("post_rst_quiet", int'(quiet), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
